banner_scroll_ctrl: RTL
=======================

Name: banner_scroll_ctrl

Overview:
- Sequences reads of a banner ROM: 57-bit rows, 8-bit address, registered address, 1-cycle read latency.
- Each display frame, streams a window of consecutive rows to the display writer over a valid/ready handshake.
- Advances a scroll offset every SCROLL_FRAMES frames so the banner scrolls and wraps continuously.
- Sits between the banner ROM and the LED-matrix row writer; paced by the display's frame tick.

Parameters:
- ROWS, 129, number of valid ROM rows; legal range 1..256.
- WIDTH, 57, ROM row width in bits.
- WINDOW, 16, rows sent per frame; must satisfy 1 <= WINDOW <= ROWS.
- SCROLL_FRAMES, 4, frames per 1-row scroll step; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock domain; reset is asynchronous and active-low
- enable  in  1  level; run scrolling when high
- frame_tick  in  1  one-cycle pulse per display frame
- rom_address  out  8  registered address to the banner ROM
- rom_data  in  WIDTH  ROM output, valid one cycle after rom_address is sampled
- out_data  out  WIDTH  row pixels
- out_row  out  clog2(WINDOW)  row index within the window
- out_valid  out  1  row available
- out_ready  in  1  writer accepts the row
- out_last  out  1  high with out_valid on row WINDOW-1
- busy  out  1  high in ISSUE, FETCH and SEND
- scroll_offset  out  8  first ROM row of the current frame
- tick_overrun  out  1  one-cycle pulse when a frame_tick is dropped

Behaviour:
- Reset: asynchronous on rst_n low.
  - state = IDLE.
  - rom_address, out_data, out_row, out_valid, out_last, busy, scroll_offset, tick_overrun, and internal frame_cnt and row_addr are all cleared to 0.
- States:
  - IDLE: if enable, go to WAIT_TICK.
  - WAIT_TICK:
    - If enable is low, go to IDLE.
    - On frame_tick: rom_address <= scroll_offset, row_addr <= scroll_offset, out_row <= 0, go to ISSUE.
  - ISSUE: the ROM samples rom_address at the end of this cycle. Go to FETCH.
  - FETCH: out_data <= rom_data, out_valid <= 1, out_last <= (out_row == WINDOW-1). Go to SEND.
  - SEND: hold out_data, out_row, out_last and out_valid stable until out_valid && out_ready. On that handshake:
    - out_valid <= 0.
    - Row not last:
      - row_addr and rom_address <= next(row_addr), where next(a) = (a == ROWS-1) ? 0 : a+1.
      - out_row <= out_row+1.
      - Go to ISSUE.
    - Row last:
      - If frame_cnt == SCROLL_FRAMES-1: frame_cnt <= 0 and scroll_offset <= next(scroll_offset). Otherwise frame_cnt <= frame_cnt+1.
      - Go to WAIT_TICK if enable, else IDLE.
- Latency: tick in cycle T gives ISSUE at T+1, FETCH at T+2, out_valid first high at T+3. With out_ready held high, one row per 3 cycles.
- Address arithmetic:
  - rom_address never exceeds ROWS-1.
  - The window wraps from ROWS-1 to 0 mid-frame. The ROM default (all-zero) rows are never addressed.
- enable is sampled only in IDLE and WAIT_TICK. Deassertion mid-frame completes the frame, including the offset update, then goes to IDLE.
- scroll_offset and frame_cnt persist through IDLE; only reset clears them.
- frame_tick in ISSUE, FETCH or SEND: tick_overrun pulses high the next cycle; the frame in progress is unaffected and the tick is not queued. frame_tick in IDLE is ignored silently.
- A handshake on the last row coincident with frame_tick: the tick is an overrun, and the state goes to WAIT_TICK.
- busy = (state is ISSUE, FETCH or SEND).

Test Plan (bench ROM model: registered address, 1-cycle latency, loaded with the banner image; defaults unless noted):
- Reset, enable=1, out_ready=1, frame_tick at cycle 10 -> rom_address=0 at cycle 11; out_valid at cycle 13 with out_data=57'h7, out_row=0; rows 0..15 sent with out_row 0..15; out_last high only on out_row=15; busy low afterwards.
- out_ready held low 5 cycles while row 3 is valid -> out_data=57'h1F8 and out_row=3 stay stable, rom_address holds 3; after ready returns, row 4 (57'h1F8) appears 3 cycles after the handshake.
- Four complete frames -> scroll_offset steps 0→1 after the 4th frame's last handshake; the 5th frame's first rom_address=1 and out_data=57'h7.
- SCROLL_FRAMES=1, run 120 frames -> scroll_offset=120; the next frame addresses 120..128 then 0..6; out_last on address 6; after the frame, scroll_offset=121.
- frame_tick pulsed during SEND of row 5 -> tick_overrun high for exactly 1 cycle; row sequence continues unchanged; no restart; next frame waits for a fresh tick.
- rst_n dropped asynchronously during SEND of row 7 -> all outputs 0 immediately, without a clock edge; after release with enable=1 and frame_tick, the frame restarts from rom_address=0.

Source files
------------

// File: rtl/banner_scroll_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : banner_scroll_ctrl
//  Description : Reads a window of consecutive rows out of a banner ROM once
//                per display frame and streams them to the LED-matrix row
//                writer over valid/ready. The window start advances by one
//                row every SCROLL_FRAMES frames and wraps at ROWS.
//  Revision    : 1.0 - initial release
// ============================================================================
module banner_scroll_ctrl #(
    parameter int ROWS          = 129,
    parameter int WIDTH         = 57,
    parameter int WINDOW        = 16,
    parameter int SCROLL_FRAMES = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             enable,
    input  logic                                             frame_tick,
    output logic [7:0]                                       rom_address,
    input  logic [WIDTH-1:0]                                 rom_data,
    output logic [WIDTH-1:0]                                 out_data,
    output logic [((WINDOW > 1) ? $clog2(WINDOW) : 1)-1:0]   out_row,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic                                             out_last,
    output logic                                             busy,
    output logic [7:0]                                       scroll_offset,
    output logic                                             tick_overrun
);

    localparam int ROW_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [ROW_W-1:0] c_LAST_ROW   = ROW_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] c_LAST_FRAME = CNT_W'(SCROLL_FRAMES - 1);
    localparam logic [7:0]       c_LAST_ADDR  = 8'(ROWS - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_WAIT_TICK = 3'd1;
    localparam logic [2:0] c_ISSUE     = 3'd2;
    localparam logic [2:0] c_FETCH     = 3'd3;
    localparam logic [2:0] c_SEND      = 3'd4;

    logic [2:0]       r_state;
    logic [7:0]       r_rom_address;
    logic [7:0]       r_row_addr;
    logic [7:0]       r_scroll_offset;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic [ROW_W-1:0] r_out_row;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_tick_overrun;
    logic             w_busy;

    // Next ROM row with wrap from the last valid row back to row 0, so the
    // all-zero tail of the ROM is never addressed.
    function automatic logic [7:0] f_next(input logic [7:0] a);
        return (a == c_LAST_ADDR) ? 8'd0 : a + 8'd1;
    endfunction

    // A frame is in flight from the address issue until the last handshake.
    always_comb begin
        w_busy = (r_state == c_ISSUE) || (r_state == c_FETCH) || (r_state == c_SEND);
    end

    // Frame sequencer: issue address, capture ROM data, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_rom_address   <= 8'd0;
            r_row_addr      <= 8'd0;
            r_scroll_offset <= 8'd0;
            r_frame_cnt     <= '0;
            r_out_data      <= '0;
            r_out_row       <= '0;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_tick_overrun  <= 1'b0;
        end else begin
            // A tick arriving mid-frame is dropped, not queued; flag it.
            r_tick_overrun <= frame_tick && w_busy;
            case (r_state)
                c_IDLE: begin
                    if (enable) r_state <= c_WAIT_TICK;
                end
                c_WAIT_TICK: begin
                    if (!enable) begin
                        r_state <= c_IDLE;
                    end else if (frame_tick) begin
                        r_rom_address <= r_scroll_offset;
                        r_row_addr    <= r_scroll_offset;
                        r_out_row     <= '0;
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // ROM captures rom_address at the end of this cycle.
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    r_out_data  <= rom_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_out_row == c_LAST_ROW);
                    r_state     <= c_SEND;
                end
                c_SEND: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (!r_out_last) begin
                            r_row_addr    <= f_next(r_row_addr);
                            r_rom_address <= f_next(r_row_addr);
                            r_out_row     <= r_out_row + ROW_W'(1);
                            r_state       <= c_ISSUE;
                        end else begin
                            if (r_frame_cnt == c_LAST_FRAME) begin
                                r_frame_cnt     <= '0;
                                r_scroll_offset <= f_next(r_scroll_offset);
                            end else begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                            r_state <= enable ? c_WAIT_TICK : c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rom_address   = r_rom_address;
    assign out_data      = r_out_data;
    assign out_row       = r_out_row;
    assign out_valid     = r_out_valid;
    assign out_last      = r_out_last;
    assign busy          = w_busy;
    assign scroll_offset = r_scroll_offset;
    assign tick_overrun  = r_tick_overrun;

endmodule
`default_nettype wire
